// File: rtl/issue_execute_fifo.sv
// FIFO between the issue stage and one execute unit, with first-word-fall-through head and flush.
// Define ISSUE_EXECUTE_FIFO_ERR_EN to add a sticky protocol-error output (err).
module issue_execute_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1,
  // Width of issue_execute_pack_t at the point of integration.
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              push,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  input  logic              pop,
  input  logic              flush
`ifdef ISSUE_EXECUTE_FIFO_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   ptr_diff;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              empty;
  logic              push_acc;
  logic              pop_acc;

  // Top pointer bit is the wrap flag: equal low bits with differing wrap bits means full.
  assign empty    = (rptr_q == wptr_q);
  assign full     = (rptr_q[AddrW-1:0] == wptr_q[AddrW-1:0]) && (rptr_q[AddrW] != wptr_q[AddrW]);
  assign ptr_diff = wptr_q - rptr_q;
  assign count    = CNT_W'(ptr_diff);

  assign data_out       = mem_q[rptr_q[AddrW-1:0]];
  assign data_out_valid = !empty;

  assign push_acc = push && !full && !flush;
  assign pop_acc  = pop && !empty && !flush;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    if (flush) begin
      rptr_d = '0;
      wptr_d = '0;
    end else begin
      if (push_acc) wptr_d = wptr_q + 1'b1;
      if (pop_acc)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wptr_q[AddrW-1:0]] <= data_in;
  end

`ifdef ISSUE_EXECUTE_FIFO_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (!flush && ((push && full) || (pop && empty))) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_issue_execute_fifo.sv
// Scoreboard bench for issue_execute_fifo: expected entries queued on accepted push, compared on pop.
module tb_issue_execute_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int DW    = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [DW-1:0]    data_in = '0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             flush = 1'b0;
  logic             full;
  logic [CNT_W-1:0] count;
  logic [DW-1:0]    data_out;
  logic             data_out_valid;
`ifdef ISSUE_EXECUTE_FIFO_ERR_EN
  logic             err;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  issue_execute_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .DATA_W(DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .push          (push),
    .full          (full),
    .count         (count),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .pop           (pop),
    .flush         (flush)
`ifdef ISSUE_EXECUTE_FIFO_ERR_EN
    ,
    .err           (err)
`endif
  );

  // Drive one cycle and advance the reference model at the edge.
  task automatic cyc(input logic p, input logic [DW-1:0] d, input logic po, input logic fl);
    int n;
    push = p; data_in = d; pop = po; flush = fl;
    @(posedge clk);
    n = sb.size();
    if (fl) sb.delete();
    else begin
      if (po && n > 0) void'(sb.pop_front());
      if (p && n < DEPTH) sb.push_back(d);
    end
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (data_out_valid !== 1'b0 || count !== 3'd0 || full !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: valid=%b count=%0d full=%b, want 0 0 0",
                 data_out_valid, count, full);
      end
    end
`ifdef ISSUE_EXECUTE_FIFO_ERR_EN
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
`endif
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] vals [4];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, vals[i], 1'b0, 1'b0);
      checks++;
      if (count !== CNT_W'(i + 1) || full !== (i == 3) || data_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL fill_status[%0d]: count=%0d full=%b valid=%b, want %0d %b 1",
                 i, count, full, data_out_valid, i + 1, (i == 3));
      end
      checks++;
      if (data_out !== 32'h11) begin
        errors++;
        $display("FAIL fill_head[%0d]: got %h want %h", i, data_out, 32'h11);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_out !== sb[0] || data_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain_data[%0d]: got %h valid=%b want %h valid=1",
                 i, data_out, data_out_valid, sb[0]);
      end
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (data_out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty: valid=%b count=%0d want 0 0", data_out_valid, count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(i * 32'h11), 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full); end
    checks++;
    if (data_out !== sb[0]) begin
      errors++;
      $display("FAIL ovf_head_before: got %h want %h", data_out, sb[0]);
    end
    cyc(1'b1, 32'h55, 1'b1, 1'b0);
    checks++;
    if (data_out !== 32'h22 || count !== 3'd3 || full !== 1'b0) begin
      errors++;
      $display("FAIL ovf_after: head=%h count=%0d full=%b want 22 3 0", data_out, count, full);
    end
`ifdef ISSUE_EXECUTE_FIFO_ERR_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", err); end
`endif
    while (sb.size() > 0) begin
      checks++;
      if (data_out !== sb[0]) begin
        errors++;
        $display("FAIL ovf_drain: got %h want %h", data_out, sb[0]);
      end
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_empty: valid=%b want 0", data_out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] v;
    cyc(1'b1, 32'hA000_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'hA000_0001, 1'b0, 1'b0);
    for (int k = 2; k < 12; k++) begin
      v = {$urandom_range(0, 255), 8'h00, 16'(k)} ^ 32'h8000_0000;
      checks++;
      if (data_out !== sb[0] || data_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_data[%0d]: got %h valid=%b want %h", k, data_out, data_out_valid, sb[0]);
      end
      cyc(1'b1, v, 1'b1, 1'b0);
      checks++;
      if (count !== 3'd2) begin
        errors++;
        $display("FAIL wrap_count[%0d]: got %0d want 2", k, count);
      end
    end
  endtask

  task automatic test_flush();
    cyc(1'b1, 32'hC0DE_0003, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL flush_pre: count=%0d want 3", count); end
    checks++;
    if (data_out !== sb[0]) begin
      errors++;
      $display("FAIL flush_head: got %h want %h", data_out, sb[0]);
    end
    cyc(1'b1, 32'h66, 1'b1, 1'b1);
    checks++;
    if (count !== 3'd0 || data_out_valid !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: count=%0d valid=%b full=%b want 0 0 0",
               count, data_out_valid, full);
    end
`ifdef ISSUE_EXECUTE_FIFO_ERR_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL flush_err_sticky: got %b want 1", err); end
`endif
    cyc(1'b1, 32'h77, 1'b0, 1'b0);
    checks++;
    if (data_out !== 32'h77 || data_out_valid !== 1'b1 || count !== 3'd1) begin
      errors++;
      $display("FAIL flush_repush: head=%h valid=%b count=%0d want 77 1 1",
               data_out, data_out_valid, count);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 32'hBEEF_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'hBEEF_0002, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd2) begin errors++; $display("FAIL areset_pre: count=%0d want 2", count); end
    #3;
    rst = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (data_out_valid !== 1'b0 || count !== 3'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: valid=%b count=%0d full=%b want 0 0 0",
               data_out_valid, count, full);
    end
`ifdef ISSUE_EXECUTE_FIFO_ERR_EN
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL areset_err: got %b want 0", err); end
`endif
    #2;
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (data_out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL areset_release: valid=%b count=%0d want 0 0", data_out_valid, count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
